// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  // Fetch addresses wrap modulo 2^32.
  function automatic logic [INSTR_W-1:0] pc_plus4(input logic [INSTR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry holding register between instruction memory and the IF/ID
// decode register: capture, drain on consume, flush on redirect.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               capture,
  input  logic               hold,
  input  logic               flush,
  input  logic [INSTR_W-1:0] cap_instr,
  input  logic [INSTR_W-1:0] cap_pc4,
  output logic [INSTR_W-1:0] instr_buf,
  output logic [INSTR_W-1:0] pc4_buf,
  output logic               bv
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_buf <= '0;
      pc4_buf   <= '0;
      bv        <= 1'b0;
    end else if (flush) begin
      bv <= 1'b0;
    end else if (capture) begin
      instr_buf <= cap_instr;
      pc4_buf   <= cap_pc4;
      bv        <= 1'b1;
    end else if (bv && !hold) begin
      // Decode register took the entry this cycle.
      bv <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, instruction-memory handshake and IF/ID control.
// Optional FETCH_STATS_EN adds FETCH_CNT / BUBBLE_CNT counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               STALLF,
  input  logic               STALLD,
  input  logic               PCSRCE,
  input  logic [INSTR_W-1:0] PCTARGETE,
  output logic               IMEM_REQ,
  output logic [INSTR_W-1:0] IMEM_ADDR,
  input  logic [INSTR_W-1:0] IMEM_RDATA,
  input  logic               IMEM_VALID,
  output logic [INSTR_W-1:0] PCF,
  output logic [INSTR_W-1:0] RD,
  output logic [INSTR_W-1:0] PCPLUS4F,
  output logic               CLRD,
  output logic               ENABLED,
  output fetch_state_e       DBG_STATE
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        FETCH_CNT,
  output logic [31:0]        BUBBLE_CNT
`endif
);

  fetch_state_e       state;
  logic [INSTR_W-1:0] pc;
  logic [INSTR_W-1:0] req_addr;
  logic [INSTR_W-1:0] instr_buf;
  logic [INSTR_W-1:0] pc4_buf;
  logic               bv;
  logic               req;
  logic               capture;
  logic               flush;

  // Memory handshake: valid/ready style with REQ as valid and IMEM_VALID as
  // the single response; once REQ rises it and the address stay stable until
  // the cycle IMEM_VALID is seen, and only one request is ever outstanding.
  always_comb begin
    req = 1'b1;
    if (state == S_IDLE) req = !STALLF && !PCSRCE && (!bv || !STALLD);
  end

  assign capture = ((state == S_IDLE) && req && IMEM_VALID) ||
                   ((state == S_WAIT) && IMEM_VALID && !PCSRCE);
  assign flush   = PCSRCE && (state != S_DISCARD);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      if (state == S_IDLE) req_addr <= pc;
      case (state)
        S_IDLE: begin
          if (PCSRCE) begin
            pc <= PCTARGETE;
          end else if (req) begin
            if (IMEM_VALID) pc <= pc_plus4(pc);
            else            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (PCSRCE) begin
            pc    <= PCTARGETE;
            state <= IMEM_VALID ? S_IDLE : S_DISCARD;
          end else if (IMEM_VALID) begin
            pc    <= pc_plus4(pc);
            state <= S_IDLE;
          end
        end
        S_DISCARD: begin
          // The stale request must still finish at its original address.
          if (PCSRCE)     pc    <= PCTARGETE;
          if (IMEM_VALID) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  fetch_buffer u_buf (
    .CLK       (CLK),
    .RST       (RST),
    .capture   (capture),
    .hold      (STALLD),
    .flush     (flush),
    .cap_instr (IMEM_RDATA),
    .cap_pc4   (pc_plus4(pc)),
    .instr_buf (instr_buf),
    .pc4_buf   (pc4_buf),
    .bv        (bv)
  );

  assign IMEM_REQ  = req;
  assign IMEM_ADDR = (state == S_DISCARD) ? req_addr : pc;
  assign PCF       = pc;
  assign RD        = bv ? instr_buf : NOP_INSTR;
  assign PCPLUS4F  = pc4_buf;
  assign CLRD      = !bv || PCSRCE;
  assign ENABLED   = STALLD && !PCSRCE;
  assign DBG_STATE = state;

`ifdef FETCH_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      FETCH_CNT  <= '0;
      BUBBLE_CNT <= '0;
    end else begin
      if (capture)           FETCH_CNT  <= FETCH_CNT + 32'd1;
      if (CLRD && !ENABLED)  BUBBLE_CNT <= BUBBLE_CNT + 32'd1;
    end
  end
`endif

endmodule
